// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the HD44780-style LCD write sequencer.
package lcd_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EN_HI,
    S_HOLD,
    S_EXEC
  } state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } cmd_t;

  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam int         FIFO_DEPTH = 4;
  localparam int         CNT_W      = 17;

  function automatic logic is_long(input cmd_t c);
    return !c.rs && (c.data == OP_CLEAR || c.data == OP_HOME);
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small command queue for the LCD sequencer; the head entry is the
// command currently executing or next to execute.
module lcd_cmd_fifo
  import lcd_seq_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic push_i,
  input  cmd_t data_i,
  input  logic pop_i,
  output cmd_t data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  cmd_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q
             + {{AW{1'b0}}, do_push}
             - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/lcd_write_sequencer.sv
// LCD write sequencer: toggle-requested writes with setup/enable/hold/exec
// timing. Define LCD_SEQ_FIFO_EN to queue up to four requests.
module lcd_write_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int unsigned SETUP_CYC     = 3,
  parameter int unsigned EN_CYC        = 12,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned EXEC_CYC      = 2000,
  parameter int unsigned EXEC_LONG_CYC = 82000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] cmd_in,
  input  logic        clr_drop,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        busy,
  output logic        dropped
);

  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] L_EN    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] L_EXEC  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] L_LONG  = CNT_W'(EXEC_LONG_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmd_t             out_q, out_d;
  logic             en_q;
  logic             tog_q;
  logic             drop_q, drop_d;

  logic req;
  cmd_t req_cmd;
  logic push;
  logic pop;
  logic drop;
  logic q_empty;
  logic q_full;
  cmd_t q_head;
  logic unused_rsvd;

  assign unused_rsvd = cmd_in[9];
  assign req         = cmd_in[10] ^ tog_q;
  assign req_cmd     = cmd_t'(cmd_in[8:0]);
  assign push        = req && (!q_full || pop);
  assign drop        = req && !push;

`ifdef LCD_SEQ_FIFO_EN
  lcd_cmd_fifo u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  (req_cmd),
    .pop_i   (pop),
    .data_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );
`else
  logic valid_q;
  cmd_t cmd_q;

  assign q_empty = !valid_q;
  assign q_full  = valid_q;
  assign q_head  = cmd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      cmd_q   <= '0;
    end else if (push) begin
      valid_q <= 1'b1;
      cmd_q   <= req_cmd;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end
`endif

  // Queue entry stays until its EXEC ends, so an idle empty queue
  // starts straight from the request word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!q_empty || req) begin
          state_d = S_SETUP;
          cnt_d   = L_SETUP;
          out_d   = q_empty ? req_cmd : q_head;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_EN_HI;
          cnt_d   = L_EN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EN_HI: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = L_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_EXEC;
          cnt_d   = is_long(out_q) ? L_LONG : L_EXEC;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          pop     = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (clr_drop) drop_d = 1'b0;
    if (drop)     drop_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      en_q    <= 1'b0;
      tog_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      en_q    <= (state_d == S_EN_HI);
      tog_q   <= cmd_in[10];
      drop_q  <= drop_d;
    end
  end

  assign lcd_data = out_q.data;
  assign lcd_rs   = out_q.rs;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = en_q;
  assign busy     = (state_q != S_IDLE) || !q_empty;
  assign dropped  = drop_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed self-checking bench for lcd_write_sequencer.
module tb_lcd_write_sequencer;

  logic        clk;
  logic        reset_n;
  logic [10:0] cmd_in;
  logic        clr_drop;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic        busy;
  logic        dropped;

  int   checks;
  int   errors;
  logic tog;

  lcd_write_sequencer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_in   (cmd_in),
    .clr_drop (clr_drop),
    .lcd_data (lcd_data),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .busy     (busy),
    .dropped  (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic r9, input logic rs, input logic [7:0] d);
    tog    = ~tog;
    cmd_in = {tog, r9, rs, d};
  endtask

  task automatic test_reset;
    reset_n  = 1'b0;
    cmd_in   = '0;
    clr_drop = 1'b0;
    tog      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (lcd_data !== 8'h00 || lcd_rs !== 1'b0 || lcd_rw !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus: data=%h rs=%b rw=%b want 00 0 0",
               lcd_data, lcd_rs, lcd_rw);
    end
    checks++;
    if (lcd_en !== 1'b0 || busy !== 1'b0 || dropped !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: en=%b busy=%b dropped=%b want 0 0 0",
               lcd_en, busy, dropped);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // Request at cycle 0; records enable window and busy around the end.
  task automatic run_cmd(input string nm, input logic rs,
                         input logic [7:0] d, input int total);
    int   first_en, last_en, en_cnt;
    logic data_ok, b1, b_late, b_done;
    first_en = -1; last_en = -1; en_cnt = 0; data_ok = 1'b1;
    b1 = 1'b0; b_late = 1'b0; b_done = 1'b1;
    for (int k = 0; k <= total + 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) send(1'b1, rs, d);
      @(negedge clk);
      if (lcd_en === 1'b1) begin
        if (first_en < 0) first_en = k;
        last_en = k;
        en_cnt++;
      end
      if (k >= 1 && k <= 17 && (lcd_data !== d || lcd_rs !== rs))
        data_ok = 1'b0;
      if (k == 1)         b1     = busy;
      if (k == total)     b_late = busy;
      if (k == total + 1) b_done = busy;
    end
    checks++;
    if (first_en != 4 || last_en != 15 || en_cnt != 12) begin
      errors++;
      $display("FAIL %s_en: first=%0d last=%0d n=%0d want 4 15 12",
               nm, first_en, last_en, en_cnt);
    end
    checks++;
    if (!data_ok) begin
      errors++;
      $display("FAIL %s_data: data=%h rs=%b want %h %b",
               nm, lcd_data, lcd_rs, d, rs);
    end
    checks++;
    if (b1 !== 1'b1 || b_late !== 1'b1 || b_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: start=%b last=%b after=%b want 1 1 0",
               nm, b1, b_late, b_done);
    end
    checks++;
    if (lcd_rw !== 1'b0 || dropped !== 1'b0) begin
      errors++;
      $display("FAIL %s_rw_drop: rw=%b dropped=%b want 0 0",
               nm, lcd_rw, dropped);
    end
  endtask

  task automatic test_normal;
    run_cmd("normal", 1'b1, 8'h41, 3 + 12 + 2 + 2000);
  endtask

  task automatic test_clear;
    run_cmd("clear", 1'b0, 8'h01, 3 + 12 + 2 + 82000);
  endtask

  task automatic test_drop;
    int   first_en, last_en, c_first, c_cnt;
    logic data_ok, d101, d201, d_end, b2018, b4036;
    logic [7:0] d2018, d2019;
    logic r2019, e2021;
    first_en = -1; last_en = -1; c_first = -1; c_cnt = 0;
    data_ok = 1'b1; d101 = 1'b0; d201 = 1'b1; d_end = 1'b1;
    b2018 = 1'b0; b4036 = 1'b1; d2018 = '0; d2019 = '0;
    r2019 = 1'b1; e2021 = 1'b1;
    for (int k = 0; k <= 4040; k++) begin
      @(posedge clk);
      #1;
      if (k == 0)    send(1'b0, 1'b1, 8'h55);
      if (k == 100)  send(1'b0, 1'b1, 8'hAA);
      if (k == 200)  clr_drop = 1'b1;
      if (k == 201)  clr_drop = 1'b0;
      if (k == 2017) send(1'b0, 1'b0, 8'h38);
      @(negedge clk);
      if (lcd_en === 1'b1 && k <= 2017) begin
        if (first_en < 0) first_en = k;
        last_en = k;
      end
      if (lcd_en === 1'b1 && k > 2017) begin
        if (c_first < 0) c_first = k;
        c_cnt++;
      end
      if (k >= 1 && k <= 17 && (lcd_data !== 8'h55 || lcd_rs !== 1'b1))
        data_ok = 1'b0;
      if (k == 101)  d101 = dropped;
      if (k == 201)  d201 = dropped;
      if (k == 2018) begin b2018 = busy; d2018 = lcd_data; end
      if (k == 2019) begin d2019 = lcd_data; r2019 = lcd_rs; end
      if (k == 2021) e2021 = lcd_en;
      if (k == 2030) d_end = dropped;
      if (k == 4036) b4036 = busy;
    end
    checks++;
    if (d101 !== 1'b1) begin
      errors++;
      $display("FAIL drop_set: dropped=%b want 1", d101);
    end
    checks++;
    if (first_en != 4 || last_en != 15 || !data_ok) begin
      errors++;
      $display("FAIL drop_first_cmd: en %0d..%0d ok=%b want 4..15 1",
               first_en, last_en, data_ok);
    end
    checks++;
    if (d201 !== 1'b0) begin
      errors++;
      $display("FAIL clr_drop: dropped=%b want 0", d201);
    end
    checks++;
    if (b2018 !== 1'b1 || d2018 !== 8'h55) begin
      errors++;
      $display("FAIL edge_pending: busy=%b data=%h want 1 55",
               b2018, d2018);
    end
    checks++;
    if (d2019 !== 8'h38 || r2019 !== 1'b0 || e2021 !== 1'b0) begin
      errors++;
      $display("FAIL edge_setup: data=%h rs=%b en=%b want 38 0 0",
               d2019, r2019, e2021);
    end
    checks++;
    if (c_first != 2022 || c_cnt != 12) begin
      errors++;
      $display("FAIL edge_en: first=%0d n=%0d want 2022 12",
               c_first, c_cnt);
    end
    checks++;
    if (d_end !== 1'b0 || b4036 !== 1'b0) begin
      errors++;
      $display("FAIL edge_end: dropped=%b busy=%b want 0 0",
               d_end, b4036);
    end
  endtask

  task automatic test_fifo;
    logic [7:0] seq [8];
    int   n;
    int   done_k;
    logic prev_en, d4, d5;
    n = 0; done_k = -1; prev_en = 1'b0; d4 = 1'b1; d5 = 1'b0;
    for (int i = 0; i < 8; i++) seq[i] = '0;
    for (int k = 0; k < 9000 && done_k < 0; k++) begin
      @(posedge clk);
      #1;
      if (k <= 4) send(1'b0, 1'b1, 8'h10 + 8'(k));
      @(negedge clk);
      if (lcd_en === 1'b1 && !prev_en && n < 8) begin
        seq[n] = lcd_data;
        n++;
      end
      prev_en = lcd_en;
      if (k == 4) d4 = dropped;
      if (k == 5) d5 = dropped;
      if (k > 5 && busy === 1'b0) done_k = k;
    end
    checks++;
    if (done_k < 0) begin
      errors++;
      $display("FAIL fifo_timeout: busy=%b still high", busy);
    end
    checks++;
    if (d4 !== 1'b0 || d5 !== 1'b1) begin
      errors++;
      $display("FAIL fifo_drop: k4=%b k5=%b want 0 1", d4, d5);
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL fifo_count: cmds=%0d want 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seq[i] !== 8'h10 + 8'(i)) begin
        errors++;
        $display("FAIL fifo_order%0d: data=%h want %h",
                 i, seq[i], 8'h10 + 8'(i));
      end
    end
    @(posedge clk);
    #1 clr_drop = 1'b1;
    @(posedge clk);
    #1 clr_drop = 1'b0;
  endtask

  task automatic test_async_reset;
    logic pre_en, bad;
    pre_en = 1'b0; bad = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) send(1'b0, 1'b1, 8'h77);
      @(negedge clk);
      if (k == 6) pre_en = lcd_en;
    end
    checks++;
    if (pre_en !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: en=%b want 1", pre_en);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (lcd_en !== 1'b0 || busy !== 1'b0 || lcd_data !== 8'h00) begin
      errors++;
      $display("FAIL arst_now: en=%b busy=%b data=%h want 0 0 00",
               lcd_en, busy, lcd_data);
    end
    cmd_in = '0;
    tog    = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (lcd_en !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL arst_after: en=%b busy=%b want idle", lcd_en, busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_normal();
    test_clear();
`ifdef LCD_SEQ_FIFO_EN
    test_fifo();
`else
    test_drop();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
